// File: rtl/mem_bus_adapter_pkg.sv
// mem_defs: shared state type, width codes and lane helpers
// for the controller-to-memory bus adapter.
package mem_defs;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE,
        S_FAIL
    } mem_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int TIMEOUT_DEF = 255;

    // Legal width code for the direction, and natural alignment
    function automatic logic req_ok(
        input logic       wr,
        input logic [2:0] f3,
        input logic [1:0] o
    );
        logic ok;
        ok = 1'b0;
        unique case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~o[0];
            3'b010:  ok = (o == 2'b00);
            3'b100:  ok = ~wr;
            3'b101:  ok = ~wr & ~o[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte lanes touched by an access of this width at offset o
    function automatic logic [3:0] be_gen(
        input logic [2:0] f3,
        input logic [1:0] o
    );
        logic [3:0] be;
        unique case (f3[1:0])
            2'b00:   be = 4'b0001 << o;
            2'b01:   be = 4'b0011 << o;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data so every enabled lane sees the right bytes
    function automatic logic [31:0] wdata_gen(
        input logic [2:0]  f3,
        input logic [31:0] wd
    );
        logic [31:0] r;
        unique case (f3[1:0])
            2'b00:   r = {4{wd[7:0]}};
            2'b01:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_bus_adapter_load_align.sv
// load_align: picks the addressed lane of a memory word and
// sign/zero-extends it; shared with the datapath writeback path.
module load_align
    import mem_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [15:0] lane;

    // Shift the addressed lane down to bit 0, then extend by width code
    always_comb begin
        lane   = 16'(rdata >> {offset, 3'b000});
        result = '0;
        unique case (funct3)
            F3_LB:   result = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   result = {{16{lane[15]}}, lane[15:0]};
            F3_LW:   result = rdata;
            F3_LBU:  result = {24'b0, lane[7:0]};
            F3_LHU:  result = {16'b0, lane[15:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_bus_adapter.sv
// mem_bus_adapter: turns a one-cycle controller request into a
// held mem_req/mem_ack transaction with lane handling and timeout.
module mem_bus_adapter
    import mem_defs::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              stall,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_MAX  = {TW{1'b1}};

    mem_state_t        state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              mreq_q, mreq_d;
    logic              stall_q, stall_d;
    logic              rsp_q, rsp_d;
    logic              err_q, err_d;
    logic [31:0]       aligned;

    load_align u_align (
        .rdata  (mem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .result (aligned)
    );

    // Next state, request capture, timer and registered output values
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        off_d   = off_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_ok(req_write, req_funct3, req_addr[1:0])) begin
                        state_d = S_ISSUE;
                        timer_d = '0;
                        we_d    = req_write;
                        addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        be_d    = be_gen(req_funct3, req_addr[1:0]);
                        wdata_d = wdata_gen(req_funct3, req_wdata);
                        off_d   = req_addr[1:0];
                        f3_d    = req_funct3;
                    end else begin
                        state_d = S_FAIL;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                    rdata_d = we_q ? 32'h0 : aligned;
                end else if (timer_q == T_LAST) begin
                    state_d = S_FAIL;
                end else if (timer_q != T_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
                if (state_d != S_ISSUE) begin
                    we_d    = 1'b0;
                    addr_d  = '0;
                    be_d    = '0;
                    wdata_d = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
        mreq_d  = (state_d == S_ISSUE);
        stall_d = (state_d == S_ISSUE) || (state_d == S_DONE);
        rsp_d   = (state_d == S_DONE);
        err_d   = (state_d == S_FAIL);
    end

    // State and output registers; reset abandons any transaction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
            ready_q <= 1'b1;
            mreq_q  <= 1'b0;
            stall_q <= 1'b0;
            rsp_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            mreq_q  <= mreq_d;
            stall_q <= stall_d;
            rsp_q   <= rsp_d;
            err_q   <= err_d;
        end
    end

    // Ready is masked while reset is held so all outputs read 0 then
    assign req_ready = ready_q & reset_n;
    assign rsp_valid = rsp_q;
    assign rsp_rdata = rdata_q;
    assign stall     = stall_q;
    assign err       = err_q;
    assign mem_req   = mreq_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_adapter.sv
// tb_mem_bus_adapter: randomized transactions checked every cycle
// against a transaction-level model, plus directed literal cases.
module tb_mem_bus_adapter;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        stall;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    mem_bus_adapter #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .stall      (stall),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic        e_ready, e_rsp, e_stall, e_err, e_mreq, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_rdata;

    int          n_rsp = 0, n_err = 0, n_mreq = 0;
    logic [31:0] l_rdata, l_addr, l_wdata;
    logic [3:0]  l_be;
    logic        l_we;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Expected behaviour of one request, from the width/offset rules
    function automatic void model(
        input  logic        w,
        input  logic [31:0] a,
        input  logic [2:0]  f3,
        input  logic [31:0] wd,
        input  logic [31:0] rd,
        output bit          ok,
        output logic [3:0]  be,
        output logic [31:0] mwd,
        output logic [31:0] res
    );
        int n, o;
        logic [63:0] mask, v;
        o = int'(a % 4);
        case (f3 & 3'd3)
            3'd0:    n = 1;
            3'd1:    n = 2;
            3'd2:    n = 4;
            default: n = 0;
        endcase
        ok  = (n != 0) && (f3 != 3'd6) && (f3 != 3'd7)
              && !(w && f3 >= 3'd4) && ((o % (n == 0 ? 1 : n)) == 0);
        be  = '0;
        mwd = '0;
        res = '0;
        if (ok) begin
            be = 4'(((1 << n) - 1) << o);
            for (int j = 0; j < 4; j++)
                mwd[8*j +: 8] = wd[8*(j % n) +: 8];
            if (!w) begin
                mask = (n == 4) ? 64'hFFFF_FFFF : ((64'd1 << (8*n)) - 1);
                v = ({32'd0, rd} >> (8*o)) & mask;
                if (!f3[2] && n < 4 && v[8*n-1])
                    v = v | (64'hFFFF_FFFF & ~mask);
                res = v[31:0];
            end
        end
    endfunction

    task automatic set_idle();
        e_ready = 1'b1;
        e_rsp   = 1'b0;
        e_stall = 1'b0;
        e_err   = 1'b0;
        e_mreq  = 1'b0;
    endtask

    task automatic junk_req(input bit junk);
        req_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        if (junk) begin
            req_write  = 1'($urandom_range(0, 1));
            req_addr   = $urandom;
            req_funct3 = 3'($urandom_range(0, 7));
            req_wdata  = $urandom;
        end
    endtask

    // Drive one request; dly = ISSUE cycles before ack (>=TO: none)
    task automatic run_txn(input logic w, input logic [31:0] a,
                           input logic [2:0] f3, input logic [31:0] wd,
                           input logic [31:0] rd, input int dly,
                           input bit junk);
        bit          ok, done;
        logic [3:0]  be;
        logic [31:0] mwd, res;
        model(w, a, f3, wd, rd, ok, be, mwd, res);
        @(posedge clk); #1;
        set_idle();
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_funct3 = f3;
        req_wdata  = wd;
        mem_ack    = 1'b0;
        @(posedge clk); #1;
        junk_req(junk);
        if (!ok) begin
            e_ready = 1'b0;
            e_err   = 1'b1;
            e_stall = 1'b0;
            e_mreq  = 1'b0;
            e_rsp   = 1'b0;
        end else begin
            done = 1'b0;
            for (int i = 0; i < TO && !done; i++) begin
                if (i > 0) begin
                    @(posedge clk); #1;
                    junk_req(junk);
                end
                e_ready   = 1'b0;
                e_mreq    = 1'b1;
                e_stall   = 1'b1;
                e_err     = 1'b0;
                e_rsp     = 1'b0;
                e_we      = w;
                e_addr    = a & 32'hFFFF_FFFC;
                e_be      = be;
                e_wdata   = mwd;
                mem_ack   = (i == dly);
                mem_rdata = (i == dly) ? rd : $urandom;
                if (i == dly) done = 1'b1;
            end
            @(posedge clk); #1;
            junk_req(junk);
            mem_ack   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
            e_mreq    = 1'b0;
            if (done) begin
                e_rsp   = 1'b1;
                e_stall = 1'b1;
                e_rdata = res;
            end else begin
                e_err   = 1'b1;
                e_stall = 1'b0;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ack   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        set_idle();
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                n_rsp++;
                l_rdata = rsp_rdata;
            end
            if (err) n_err++;
            if (mem_req) begin
                n_mreq++;
                l_addr  = mem_addr;
                l_be    = mem_be;
                l_wdata = mem_wdata;
                l_we    = mem_we;
            end
            if (chk_en) begin
                chk("req_ready", 32'(req_ready), 32'(e_ready));
                chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
                chk("stall", 32'(stall), 32'(e_stall));
                chk("err", 32'(err), 32'(e_err));
                chk("mem_req", 32'(mem_req), 32'(e_mreq));
                if (e_mreq) begin
                    chk("mem_we", 32'(mem_we), 32'(e_we));
                    chk("mem_addr", mem_addr, e_addr);
                    chk("mem_be", 32'(mem_be), 32'(e_be));
                    chk("mem_wdata", mem_wdata, e_wdata);
                end
                if (e_rsp) chk("rsp_rdata", rsp_rdata, e_rdata);
            end
        end
    endtask

    initial begin
        int b_rsp, b_err, b_mreq;
        fork
            compare_loop();
        join_none
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;

        b_rsp = n_rsp; b_mreq = n_mreq;
        run_txn(1'b0, 32'h100, 3'b010, 32'h0, 32'hDEADBEEF, 3, 1'b0);
        chk("lw_rsp_count", n_rsp - b_rsp, 32'd1);
        chk("lw_rdata", l_rdata, 32'hDEADBEEF);
        chk("lw_addr", l_addr, 32'h100);
        chk("lw_be", 32'(l_be), 32'hF);
        chk("lw_req_cycles", n_mreq - b_mreq, 32'd4);

        run_txn(1'b0, 32'h103, 3'b000, 32'h0, 32'h80FF_0000, 1, 1'b0);
        chk("lb_rdata", l_rdata, 32'hFFFF_FF80);
        run_txn(1'b0, 32'h103, 3'b100, 32'h0, 32'h80FF_0000, 0, 1'b0);
        chk("lbu_rdata", l_rdata, 32'h0000_0080);

        run_txn(1'b1, 32'h202, 3'b001, 32'h1234_ABCD, $urandom, 0, 1'b0);
        chk("sh_we", 32'(l_we), 32'd1);
        chk("sh_addr", l_addr, 32'h200);
        chk("sh_be", 32'(l_be), 32'hC);
        chk("sh_wdata", l_wdata, 32'hABCD_ABCD);
        chk("sh_rdata", l_rdata, 32'h0);

        b_err = n_err; b_mreq = n_mreq;
        run_txn(1'b0, 32'h101, 3'b010, 32'h0, 32'h0, 0, 1'b0);
        chk("mis_err_count", n_err - b_err, 32'd1);
        chk("mis_no_req", n_mreq - b_mreq, 32'd0);

        b_err = n_err; b_rsp = n_rsp; b_mreq = n_mreq;
        run_txn(1'b0, 32'h300, 3'b010, 32'h0, 32'h0, TO, 1'b1);
        chk("to_err_count", n_err - b_err, 32'd1);
        chk("to_no_rsp", n_rsp - b_rsp, 32'd0);
        chk("to_req_cycles", n_mreq - b_mreq, TO);

        b_err = n_err; b_rsp = n_rsp;
        run_txn(1'b0, 32'h304, 3'b010, 32'h0, 32'h5555_AAAA, TO - 1, 1'b0);
        chk("last_ack_rsp", n_rsp - b_rsp, 32'd1);
        chk("last_ack_no_err", n_err - b_err, 32'd0);

        chk_en = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0;
        req_addr = 32'h400; req_funct3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        b_rsp = n_rsp; b_err = n_err;
        chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        mem_ack = 1'b1;
        mem_rdata = $urandom;
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        set_idle();
        chk_en = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("rst_no_rsp", n_rsp - b_rsp, 32'd0);
        chk("rst_no_err", n_err - b_err, 32'd0);
        run_txn(1'b0, 32'h404, 3'b010, 32'h0, 32'hCAFE_F00D, 1, 1'b0);
        chk("post_rst_rdata", l_rdata, 32'hCAFE_F00D);
        chk("post_rst_rsp", n_rsp - b_rsp, 32'd1);

        for (int k = 0; k < 200; k++) begin
            logic        w;
            logic [2:0]  f3;
            int          dly;
            w   = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            dly = ($urandom_range(0, 39) == 0) ? TO
                                               : int'($urandom_range(0, 4));
            run_txn(w, $urandom, f3, $urandom, $urandom, dly, 1'b1);
        end

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
